// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - buffered instruction decoder: splits fetch words into fields and queues them in a FIFO
// Optional performance counters are enabled by defining DECODE_PERF_CNT_EN.
module inst_decode_queue #(
  parameter int INST_W   = 32,
  parameter int OP_W     = 3,
  parameter int RA_W     = 5,
  parameter int IMM_W    = 16,
  parameter int ADDR_W   = 32,
  parameter int SIGN_EXT = 0,
  parameter int DEPTH    = 2,
  parameter logic [2**OP_W-1:0] ILLEGAL_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   opcode,
  output logic [RA_W-1:0]   reg_addr_0,
  output logic [RA_W-1:0]   reg_addr_1,
  output logic [RA_W-1:0]   reg_addr_2,
  output logic [ADDR_W-1:0] addr,
`ifdef DECODE_PERF_CNT_EN
  output logic [31:0]       dec_count,
  output logic [15:0]       illegal_count,
`endif
  output logic              illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  logic [OP_W-1:0]   d_op;
  logic [RA_W-1:0]   d_ra0, d_ra1, d_ra2;
  logic [IMM_W-1:0]  d_field;
  logic [ADDR_W-1:0] d_addr;
  logic              d_ill;

  assign d_op    = inst[INST_W-1 -: OP_W];
  assign d_ra0   = inst[INST_W-OP_W-1 -: RA_W];
  assign d_ra1   = inst[INST_W-OP_W-RA_W-1 -: RA_W];
  assign d_ra2   = inst[INST_W-OP_W-2*RA_W-1 -: RA_W];
  assign d_field = inst[IMM_W-1:0];
  assign d_addr  = (SIGN_EXT != 0) ? ADDR_W'($signed(d_field)) : ADDR_W'(d_field);
  assign d_ill   = ILLEGAL_MASK[d_op];

  logic [OP_W-1:0]   op_mem  [DEPTH];
  logic [RA_W-1:0]   ra0_mem [DEPTH];
  logic [RA_W-1:0]   ra1_mem [DEPTH];
  logic [RA_W-1:0]   ra2_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem[DEPTH];
  logic              ill_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_mem[i]   <= '0;
        ra0_mem[i]  <= '0;
        ra1_mem[i]  <= '0;
        ra2_mem[i]  <= '0;
        addr_mem[i] <= '0;
        ill_mem[i]  <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        op_mem[wr_ptr[AW-1:0]]   <= d_op;
        ra0_mem[wr_ptr[AW-1:0]]  <= d_ra0;
        ra1_mem[wr_ptr[AW-1:0]]  <= d_ra1;
        ra2_mem[wr_ptr[AW-1:0]]  <= d_ra2;
        addr_mem[wr_ptr[AW-1:0]] <= d_addr;
        ill_mem[wr_ptr[AW-1:0]]  <= d_ill;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign opcode     = op_mem[rd_ptr[AW-1:0]];
  assign reg_addr_0 = ra0_mem[rd_ptr[AW-1:0]];
  assign reg_addr_1 = ra1_mem[rd_ptr[AW-1:0]];
  assign reg_addr_2 = ra2_mem[rd_ptr[AW-1:0]];
  assign addr       = addr_mem[rd_ptr[AW-1:0]];
  assign illegal    = ill_mem[rd_ptr[AW-1:0]];

`ifdef DECODE_PERF_CNT_EN
  // Counters survive flush; only pops that actually take effect are counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count     <= '0;
      illegal_count <= '0;
    end else if (pop && !flush) begin
      dec_count <= dec_count + 32'd1;
      if (illegal && (illegal_count != 16'hFFFF)) begin
        illegal_count <= illegal_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_decode_queue.sv
// tb/tb_inst_decode_queue.sv - randomized and directed check of inst_decode_queue against a queue model
module tb_inst_decode_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inst = 32'h0;

  logic        ir_a, ov_a, il_a, ir_b, ov_b, il_b;
  logic [2:0]  op_a, op_b;
  logic [4:0]  r0_a, r1_a, r2_a, r0_b, r1_b, r2_b;
  logic [31:0] ad_a, ad_b;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] dc_a, dc_b;
  logic [15:0] ic_a, ic_b;
`endif

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  inst_decode_queue #(.SIGN_EXT(0), .ILLEGAL_MASK(8'b1000_0000)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .inst(inst), .out_valid(ov_a), .out_ready(out_ready), .opcode(op_a),
    .reg_addr_0(r0_a), .reg_addr_1(r1_a), .reg_addr_2(r2_a), .addr(ad_a),
`ifdef DECODE_PERF_CNT_EN
    .dec_count(dc_a), .illegal_count(ic_a),
`endif
    .illegal(il_a)
  );

  inst_decode_queue #(.SIGN_EXT(1), .ILLEGAL_MASK(8'b0000_0000)) dut_sx (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
    .inst(inst), .out_valid(ov_b), .out_ready(out_ready), .opcode(op_b),
    .reg_addr_0(r0_b), .reg_addr_1(r1_b), .reg_addr_2(r2_b), .addr(ad_b),
`ifdef DECODE_PERF_CNT_EN
    .dec_count(dc_b), .illegal_count(ic_b),
`endif
    .illegal(il_b)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] w, input bit sx);
    logic [31:0] f;
    f = w & 32'h0000_FFFF;
    if (sx && f >= 32'h0000_8000) f = f | 32'hFFFF_0000;
    return f;
  endfunction

  // Reference: a queue of raw words; fields are derived from the head word on demand.
  logic [31:0] q[$];
  int unsigned m_dec = 0;
  int          m_ill = 0;
  bit          zero_head = 1'b0;
  bit          started = 1'b0;
  bit          acc;
  int          dut_pops = 0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      q.delete();
      m_dec = 0;
      m_ill = 0;
      zero_head = 1'b1;
    end else if (flush) begin
      q.delete();
      zero_head = 1'b0;
    end else begin
      acc = in_valid && (q.size() < 2);
      if (out_ready && q.size() > 0) begin
        m_dec++;
        if ((q[0] >> 29) == 7 && m_ill < 65535) m_ill++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(inst);
        zero_head = 1'b0;
      end
    end
  end

  task automatic cmp_inst(input string tag, input logic [7:0] mask, input bit sx,
                          input logic ir, input logic ov, input logic [2:0] op,
                          input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] ad, input logic il);
    logic [31:0] w;
    check({tag, "_in_ready"}, ir, (q.size() < 2) && !rst);
    check({tag, "_out_valid"}, ov, q.size() > 0);
    if (q.size() > 0) begin
      w = q[0];
      check({tag, "_opcode"}, op, w >> 29);
      check({tag, "_ra0"}, r0, (w >> 24) & 32'h1F);
      check({tag, "_ra1"}, r1, (w >> 19) & 32'h1F);
      check({tag, "_ra2"}, r2, (w >> 14) & 32'h1F);
      check({tag, "_addr"}, ad, exp_addr(w, sx));
      check({tag, "_illegal"}, il, (mask >> (w >> 29)) & 8'h1);
    end else if (zero_head) begin
      check({tag, "_rst_fields"}, {op, r0, r1, r2, ad, il}, 64'h0);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst("a", 8'h80, 1'b0, ir_a, ov_a, op_a, r0_a, r1_a, r2_a, ad_a, il_a);
      cmp_inst("sx", 8'h00, 1'b1, ir_b, ov_b, op_b, r0_b, r1_b, r2_b, ad_b, il_b);
`ifdef DECODE_PERF_CNT_EN
      check("a_dec_count", dc_a, m_dec);
      check("a_illegal_count", ic_a, m_ill);
      check("sx_dec_count", dc_b, m_dec);
      check("sx_illegal_count", ic_b, 0);
`endif
      if (ov_a && out_ready && !flush && !rst) dut_pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    tick(); tick();
    @(negedge clk);
    check("lit_rst_in_ready", ir_a, 0);
    check("lit_rst_out_valid", ov_a, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_post_rst_in_ready", ir_a, 1);

    // Default decode
    tick();
    in_valid = 1'b1; inst = 32'h4110_0008;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_dec_valid", ov_a, 1);
    check("lit_dec_opcode", op_a, 3'b010);
    check("lit_dec_ra0", r0_a, 1);
    check("lit_dec_ra1", r1_a, 2);
    check("lit_dec_ra2", r2_a, 0);
    check("lit_dec_addr", ad_a, 32'h0000_0008);
    check("lit_dec_illegal", il_a, 0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Sign versus zero extension
    in_valid = 1'b1; inst = 32'h8110_C000;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_sx_addr", ad_b, 32'hFFFF_C000);
    check("lit_sx_opcode", op_b, 3'b100);
    check("lit_zx_addr", ad_a, 32'h0000_C000);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill, back-pressure and ordering
    in_valid = 1'b1; inst = 32'h0100_0004;
    tick();
    inst = 32'h2100_0004;
    tick();
    inst = 32'hE110_C000;
    @(negedge clk);
    check("lit_full_in_ready", ir_a, 0);
    tick();
    @(negedge clk);
    check("lit_full_head_opcode", op_a, 3'b000);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("lit_order_second", op_a, 3'b001);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("lit_third_valid", ov_a, 1);
    check("lit_third_opcode", op_a, 3'b111);
    check("lit_third_illegal", il_a, 1);
    check("lit_third_illegal_sx", il_b, 0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Illegal flagging and counters from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b1; inst = 32'hE110_C000;
    tick();
    inst = 32'hC110_C000;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_ill_e", il_a, 1);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("lit_ill_c_opcode", op_a, 3'b110);
    check("lit_ill_c", il_a, 0);
    tick();
    out_ready = 1'b0;
`ifdef DECODE_PERF_CNT_EN
    @(negedge clk);
    check("lit_dec_count", dc_a, 2);
    check("lit_illegal_count", ic_a, 1);
`endif

    // Streaming at full rate
    @(negedge clk);
    base = dut_pops;
    tick();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inst = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("lit_stream_pops", dut_pops - base, 8);

    // Flush with a simultaneous push and pop
    tick();
    out_ready = 1'b0; in_valid = 1'b1; inst = $urandom;
    tick();
    flush = 1'b1; out_ready = 1'b1; inst = $urandom;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("lit_flush_empty", ov_a, 0);
    base = dut_pops;
    tick(); tick();
    @(negedge clk);
    check("lit_flush_no_pop", dut_pops - base, 0);
    tick();
    out_ready = 1'b0;

    // Reset with two entries buffered
    in_valid = 1'b1; inst = $urandom;
    tick();
    inst = $urandom;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_two_buffered", ov_a, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_mid_rst_valid", ov_a, 0);
    check("lit_mid_rst_fields", {op_a, r0_a, r1_a, r2_a, ad_a, il_a}, 64'h0);
    check("lit_mid_rst_in_ready", ir_a, 1);
`ifdef DECODE_PERF_CNT_EN
    check("lit_mid_rst_counters", {dc_a, ic_a}, 64'h0);
`endif

    // Random traffic; a stalled word is held until accepted
    for (int i = 0; i < 400; i++) begin
      tick();
      rst = ($urandom % 50) == 0;
      flush = ($urandom % 25) == 0;
      if (!(in_valid && !ir_a)) begin
        in_valid = $urandom % 2;
        inst = $urandom;
      end
      out_ready = $urandom % 2;
    end
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
